// File: rtl/alu_op_stage.sv
// Command sequencer around a combinational N-bit ALU: latches operands, captures
// the 2N-bit result, hands it downstream and keeps an accumulator for chaining.
module alu_op_stage #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [1:0]     in_func,
  input  logic           in_acc,
  input  logic           acc_clr,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [1:0]     alu_func,
  input  logic [2*N-1:0] alu_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_result,
  output logic [2*N-1:0] acc_value,
  output logic [7:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;

  logic [N-1:0] next_b;
  logic         consume;

  // Handshake flags depend on state (and out_ready for back-to-back) only.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign consume   = (state == HOLD) && out_ready;

  // In a back-to-back chain acc_value already holds the result being consumed.
  assign next_b = in_acc ? acc_value[N-1:0] : in_b;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      out_result <= '0;
      acc_value  <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a    <= in_a;
            alu_b    <= next_b;
            alu_func <= in_func;
            state    <= EXEC;
          end
        end
        EXEC: begin
          out_result <= alu_out;
          acc_value  <= alu_out;
          state      <= HOLD;
        end
        HOLD: begin
          if (consume) begin
            op_count <= op_count + 8'd1;
            if (in_valid) begin
              alu_a    <= in_a;
              alu_b    <= next_b;
              alu_func <= in_func;
              state    <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Clear wins over the capture and the increment above.
      if (acc_clr) begin
        acc_value <= '0;
        op_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_stage.sv
// Directed bench for alu_op_stage with a behavioural ALU closing the loop.
module tb_alu_op_stage;

  localparam int N = 4;

  logic           Clock = 1'b0;
  logic           Resetn;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [1:0]     in_func;
  logic           in_acc;
  logic           acc_clr;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [1:0]     alu_func;
  logic [2*N-1:0] alu_out;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_result;
  logic [2*N-1:0] acc_value;
  logic [7:0]     op_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_stage #(.N(N)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_acc(in_acc),
    .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .acc_value(acc_value), .op_count(op_count)
  );

  always #5 Clock = ~Clock;

  // Reference ALU
  always_comb begin
    alu_out = '0;
    case (alu_func)
      2'b00: alu_out = {{N{1'b0}}, alu_a} + {{N{1'b0}}, alu_b};
      2'b01: alu_out = {{(2*N-1){1'b0}}, |(alu_a | alu_b)};
      2'b10: alu_out = {{(2*N-1){1'b0}}, &(alu_a & alu_b)};
      default: alu_out = {alu_a, alu_b};
    endcase
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a command for one edge; returns 1 ns after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [1:0] f, input logic acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_func  = f;
    in_acc   = acc;
    tick();
    in_valid = 1'b0;
    in_acc   = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_func = '0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
    send(4'h3, 4'h5, 2'b11, 1'b0);
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    n_checks++; if (out_result !== 8'h35) begin n_fail++; $display("FAIL pre_reset_result: got %h want 35", out_result); end
    #2;
    Resetn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", out_result); end
    n_checks++; if (acc_value !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h want 00", acc_value); end
    n_checks++; if (op_count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", op_count); end
    n_checks++; if ({alu_a, alu_b, alu_func} !== 10'h000) begin n_fail++; $display("FAIL reset_alu_in: got %h want 000", {alu_a, alu_b, alu_func}); end
    tick();
    Resetn = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic_add();
    out_ready = 1'b1;
    send(4'h9, 4'h7, 2'b00, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec_valid: got %b want 0", out_valid); end
    n_checks++; if ({alu_a, alu_b} !== 8'h97) begin n_fail++; $display("FAIL add_operands: got %h want 97", {alu_a, alu_b}); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec_ready: got %b want 0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_checks++; if (out_result !== 8'h10) begin n_fail++; $display("FAIL add_result: got %h want 10", out_result); end
    tick();
    n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", op_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(4'h3, 4'h5, 2'b11, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_result !== 8'h35 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got res=%h vld=%b rdy=%b want 35/1/0", i, out_result, out_valid, in_ready);
      end
      n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 1", i, op_count); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick();
    out_ready = 1'b0;
    tick();
    n_checks++; if (op_count !== 8'd2) begin n_fail++; $display("FAIL stall_count_once: got %0d want 2", op_count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(4'h3, 4'h5, 2'b00, 1'b0);
    tick();
    n_checks++; if (out_result !== 8'h08 || out_valid !== 1'b1) begin n_fail++; $display("FAIL chain_first: got %h/%b want 08/1", out_result, out_valid); end
    send(4'h4, 4'hF, 2'b00, 1'b1);
    n_checks++; if (alu_b !== 4'h8 || alu_a !== 4'h4) begin n_fail++; $display("FAIL chain_operands: got a=%h b=%h want 4/8", alu_a, alu_b); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL chain_gap: got %b want 0", out_valid); end
    n_checks++; if (op_count !== 8'd3) begin n_fail++; $display("FAIL chain_count1: got %0d want 3", op_count); end
    tick();
    n_checks++; if (out_result !== 8'h0C || out_valid !== 1'b1) begin n_fail++; $display("FAIL chain_second: got %h/%b want 0c/1", out_result, out_valid); end
    n_checks++; if (acc_value !== 8'h0C) begin n_fail++; $display("FAIL chain_acc: got %h want 0c", acc_value); end
    tick();
    n_checks++; if (op_count !== 8'd4) begin n_fail++; $display("FAIL chain_count2: got %0d want 4", op_count); end
  endtask

  task automatic test_reductions();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [1:0] vf [3];
    logic [7:0] ve [3];
    va = '{4'h0, 4'hF, 4'hF};
    vb = '{4'h0, 4'hF, 4'hE};
    vf = '{2'b01, 2'b10, 2'b10};
    ve = '{8'h00, 8'h01, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vf[i], 1'b0);
      tick();
      n_checks++; if (out_result !== ve[i] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL reduce[%0d]: got %h/%b want %h/1", i, out_result, out_valid, ve[i]);
      end
      tick();
    end
    n_checks++; if (op_count !== 8'd7) begin n_fail++; $display("FAIL reduce_count: got %0d want 7", op_count); end
  endtask

  task automatic test_acc_clr();
    out_ready = 1'b1;
    send(4'h2, 4'h3, 2'b00, 1'b0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    n_checks++; if (out_result !== 8'h05 || out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_result: got %h/%b want 05/1", out_result, out_valid); end
    n_checks++; if (acc_value !== 8'h00) begin n_fail++; $display("FAIL clr_acc: got %h want 00", acc_value); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", op_count); end
    tick();
    n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL clr_count_after: got %0d want 1", op_count); end
    for (int i = 0; i < 255; i++) begin
      send(4'h1, 4'h2, 2'b00, 1'b0);
      tick();
      tick();
      if (i == 253) begin
        n_checks++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", op_count); end
      end
    end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
    n_checks++; if (acc_value !== 8'h03) begin n_fail++; $display("FAIL wrap_acc: got %h want 03", acc_value); end
    // Clear coinciding with an accumulate accept: B takes the pre-clear value.
    acc_clr = 1'b1;
    send(4'h0, 4'h9, 2'b00, 1'b1);
    acc_clr = 1'b0;
    n_checks++; if (alu_b !== 4'h3) begin n_fail++; $display("FAIL clr_accept_b: got %h want 3", alu_b); end
    n_checks++; if (acc_value !== 8'h00) begin n_fail++; $display("FAIL clr_accept_acc: got %h want 00", acc_value); end
    tick();
    n_checks++; if (out_result !== 8'h03 || acc_value !== 8'h03) begin n_fail++; $display("FAIL clr_accept_result: got %h/%h want 03/03", out_result, acc_value); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_stall();
    test_back_to_back();
    test_reductions();
    test_acc_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
